// File: rtl/uart_word_tx_ctrl_pkg.sv
// uart_ctrl_pkg: state encoding and requester IDs shared by the UART word controller.
// No ports; imported by rr_arb2 and uart_word_tx_ctrl.
package uart_ctrl_pkg;
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND      = 3'd1,
        WAIT_ACT  = 3'd2,
        WAIT_DONE = 3'd3,
        WAIT_REL  = 3'd4
    } state_t;
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;
endpackage

// File: rtl/uart_word_tx_ctrl_if.sv
// uart_word_tx_ctrl_if: requester/transmitter handshake bundle for uart_word_tx_ctrl.
// Requester side: ReqN_Valid/ReqN_Word in, ReqN_Ack out.
// Transmitter side: Tx_DV/Tx_Byte out, Tx_Active/Tx_Done in.
// Status: Busy, Grant, Byte_Idx, Word_Done out.
// slave = controller view, master = surrounding system view.
interface uart_word_tx_ctrl_if #(parameter int NUM_BYTES = 32);
    localparam int IW = $clog2(NUM_BYTES);
    logic                   i_Req0_Valid;
    logic [8*NUM_BYTES-1:0] i_Req0_Word;
    logic                   o_Req0_Ack;
    logic                   i_Req1_Valid;
    logic [8*NUM_BYTES-1:0] i_Req1_Word;
    logic                   o_Req1_Ack;
    logic                   o_Tx_DV;
    logic [7:0]             o_Tx_Byte;
    logic                   i_Tx_Active;
    logic                   i_Tx_Done;
    logic                   o_Busy;
    logic                   o_Grant;
    logic [IW-1:0]          o_Byte_Idx;
    logic                   o_Word_Done;
    modport slave (
        input  i_Req0_Valid, i_Req0_Word, i_Req1_Valid, i_Req1_Word, i_Tx_Active, i_Tx_Done,
        output o_Req0_Ack, o_Req1_Ack, o_Tx_DV, o_Tx_Byte, o_Busy, o_Grant, o_Byte_Idx, o_Word_Done
    );
    modport master (
        output i_Req0_Valid, i_Req0_Word, i_Req1_Valid, i_Req1_Word, i_Tx_Active, i_Tx_Done,
        input  o_Req0_Ack, o_Req1_Ack, o_Tx_DV, o_Tx_Byte, o_Busy, o_Grant, o_Byte_Idx, o_Word_Done
    );
endinterface

// File: rtl/uart_word_tx_ctrl_rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick.
// Ports: req0_valid/req1_valid requests, last = ID served most recently,
//        gnt_valid = some request present, gnt_id = winning requester.
module rr_arb2
    import uart_ctrl_pkg::*;
(
    input  logic req0_valid,
    input  logic req1_valid,
    input  logic last,
    output logic gnt_valid,
    output logic gnt_id
);
    always_comb begin
        gnt_valid = req0_valid | req1_valid;
        // On a tie the requester not served last wins, so neither can starve.
        gnt_id    = (req0_valid & req1_valid) ? ~last : (req1_valid ? REQ1 : REQ0);
    end
endmodule

// File: rtl/uart_word_tx_ctrl.sv
// uart_word_tx_ctrl: shares a byte-wide UART transmitter between two word producers.
// Ports: i_Clock, i_Reset (sync, active-high), bus (slave modport) carrying the
//        requester valid/word/ack pairs, the transmitter DV/byte/Active/Done
//        handshake and the Busy/Grant/Byte_Idx/Word_Done status.
module uart_word_tx_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_BYTES = 32
) (
    input logic                i_Clock,
    input logic                i_Reset,
    uart_word_tx_ctrl_if.slave bus
);
    localparam int IW = $clog2(NUM_BYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BYTES - 1);

    state_t                 state_q;
    logic [8*NUM_BYTES-1:0] word_q;
    logic [IW-1:0]          idx_q;
    logic [7:0]             byte_q;
    logic                   grant_q;
    logic                   last_q;
    logic                   final_q;
    logic                   ack0_q;
    logic                   ack1_q;
    logic                   dv_q;
    logic                   word_done_q;
    logic                   gnt_valid;
    logic                   gnt_id;

    rr_arb2 u_arb (
        .req0_valid (bus.i_Req0_Valid),
        .req1_valid (bus.i_Req1_Valid),
        .last       (last_q),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q     <= IDLE;
            word_q      <= '0;
            idx_q       <= '0;
            byte_q      <= '0;
            grant_q     <= REQ0;
            last_q      <= REQ1;
            final_q     <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            dv_q        <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            dv_q        <= 1'b0;
            word_done_q <= 1'b0;
            case (state_q)
                // The transmitter is never reset by us, so wait for it to be
                // fully quiet before granting a new word.
                IDLE: if (gnt_valid && !bus.i_Tx_Active && !bus.i_Tx_Done) begin
                    word_q  <= gnt_id ? bus.i_Req1_Word : bus.i_Req0_Word;
                    grant_q <= gnt_id;
                    idx_q   <= '0;
                    final_q <= 1'b0;
                    ack0_q  <= gnt_id == REQ0;
                    ack1_q  <= gnt_id == REQ1;
                    state_q <= SEND;
                end
                SEND: begin
                    byte_q  <= word_q[8*idx_q +: 8];
                    dv_q    <= 1'b1;
                    state_q <= WAIT_ACT;
                end
                WAIT_ACT: if (bus.i_Tx_Active) state_q <= WAIT_DONE;
                // The index holds at the last byte; final_q remembers that the
                // word is finished so WAIT_REL can tell it from byte NUM_BYTES-2.
                WAIT_DONE: if (bus.i_Tx_Done) begin
                    if (idx_q == LAST_IDX) begin
                        word_done_q <= 1'b1;
                        last_q      <= grant_q;
                        final_q     <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                    state_q <= WAIT_REL;
                end
                WAIT_REL: if (!bus.i_Tx_Done) state_q <= final_q ? IDLE : SEND;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_Req0_Ack  = ack0_q;
    assign bus.o_Req1_Ack  = ack1_q;
    assign bus.o_Tx_DV     = dv_q;
    assign bus.o_Tx_Byte   = byte_q;
    assign bus.o_Busy      = state_q != IDLE;
    assign bus.o_Grant     = grant_q;
    assign bus.o_Byte_Idx  = idx_q;
    assign bus.o_Word_Done = word_done_q;
endmodule

// File: tb/tb_uart_word_tx_ctrl.sv
// tb_uart_word_tx_ctrl: directed + randomized bench with a behavioural UART transmitter.
module tb_uart_word_tx_ctrl;
    localparam int NB           = 32;
    localparam int CLKS_PER_BIT = 4;
    localparam int FRAME        = 10 * CLKS_PER_BIT;
    localparam int DONE_CYC     = 2;
    // Byte-to-byte DV spacing: frame + Done high time + (Done=0 seen, SEND, DV).
    localparam int DV_GAP       = FRAME + DONE_CYC + 3;
    // Active is seen one cycle after DV; Done is seen at the end of its first cycle.
    localparam int WD_LAG       = FRAME + 2;

    typedef struct packed {
        logic       g;
        logic [7:0] idx;
        logic [7:0] b;
    } obs_t;

    logic i_Clock = 1'b0;
    logic i_Reset = 1'b1;

    uart_word_tx_ctrl_if #(.NUM_BYTES(NB)) bus ();

    uart_word_tx_ctrl #(.NUM_BYTES(NB)) dut (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .bus     (bus)
    );

    always #5 i_Clock = ~i_Clock;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int act_left = 0, done_left = 0;
    int last_dv_cyc = 0, dv0_cyc = 0, ack_cyc = 0, wd_cnt = 0;
    logic dv_p = 1'b0, ack0_p = 1'b0, ack1_p = 1'b0;
    logic pulse1 = 1'b0;
    logic [8*NB-1:0] q0[$], q1[$];
    logic [8*NB-1:0] junk1 = '0;
    obs_t seen[$];
    int   ack_ids[$];
    int   gnt_seen[$];

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8*NB-1:0] rand_word();
        logic [8*NB-1:0] w;
        for (int i = 0; i < NB / 4; i++) w[32*i +: 32] = $urandom;
        return w;
    endfunction

    task automatic drive_reqs();
        bus.i_Req0_Valid = q0.size() > 0;
        bus.i_Req0_Word  = q0.size() > 0 ? q0[0] : '0;
        bus.i_Req1_Valid = q1.size() > 0 || pulse1;
        bus.i_Req1_Word  = q1.size() > 0 ? q1[0] : junk1;
    endtask

    // One clock: transmitter model reacts to last cycle's DV, then outputs are observed.
    task automatic step();
        obs_t o;
        @(posedge i_Clock);
        #1;
        cyc++;
        if (act_left > 0) begin
            act_left--;
            if (act_left == 0) done_left = DONE_CYC;
        end else if (done_left > 0) begin
            done_left--;
        end else if (dv_p) begin
            act_left = FRAME;
        end
        bus.i_Tx_Active = act_left > 0;
        bus.i_Tx_Done   = done_left > 0;
        if (bus.o_Tx_DV) begin
            check("dv_while_tx_busy", {bus.i_Tx_Active, bus.i_Tx_Done}, 0);
            if (bus.o_Byte_Idx != 0) check("dv_gap", cyc - last_dv_cyc, DV_GAP);
            else dv0_cyc = cyc;
            last_dv_cyc = cyc;
            o.g   = bus.o_Grant;
            o.idx = 8'(bus.o_Byte_Idx);
            o.b   = bus.o_Tx_Byte;
            seen.push_back(o);
        end
        if (bus.o_Req0_Ack) begin
            check("ack0_width", ack0_p, 0);
            ack_ids.push_back(0);
            ack_cyc = cyc;
            if (q0.size() > 0) void'(q0.pop_front());
        end
        if (bus.o_Req1_Ack) begin
            check("ack1_width", ack1_p, 0);
            ack_ids.push_back(1);
            ack_cyc = cyc;
            if (q1.size() > 0) void'(q1.pop_front());
        end
        if (bus.o_Word_Done) begin
            wd_cnt++;
            check("word_done_lag", cyc - last_dv_cyc, WD_LAG);
            gnt_seen.push_back(int'(bus.o_Grant));
        end
        dv_p   = bus.o_Tx_DV;
        ack0_p = bus.o_Req0_Ack;
        ack1_p = bus.o_Req1_Ack;
        drive_reqs();
    endtask

    task automatic do_reset();
        i_Reset = 1'b1;
        q0.delete();
        q1.delete();
        pulse1 = 1'b0;
        drive_reqs();
        step();
        step();
        i_Reset = 1'b0;
        seen.delete();
        ack_ids.delete();
        gnt_seen.delete();
        wd_cnt = 0;
    endtask

    task automatic wait_words(int n, string tag);
        int budget = n * NB * (DV_GAP + 2) + 200;
        while (wd_cnt < n && budget > 0) begin
            step();
            budget--;
        end
        check(tag, wd_cnt >= n, 1);
    endtask

    task automatic wait_dv(int n, string tag);
        int budget = n * (DV_GAP + 2) + 200;
        while (seen.size() < n && budget > 0) begin
            step();
            budget--;
        end
        check(tag, seen.size() >= n, 1);
    endtask

    task automatic check_word(string tag, logic [8*NB-1:0] w, logic g, int start);
        check({tag, "_len"}, seen.size() >= start + NB, 1);
        if (seen.size() >= start + NB)
            for (int k = 0; k < NB; k++)
                check(tag, seen[start + k], {g, 8'(k), w[8*k +: 8]});
    endtask

    task automatic check_acks(string tag, int a, int b, int n);
        check({tag, "_n"}, ack_ids.size(), n);
        if (ack_ids.size() >= 1) check({tag, "_0"}, ack_ids[0], a);
        if (ack_ids.size() >= 2 && n >= 2) check({tag, "_1"}, ack_ids[1], b);
    endtask

    task automatic check_reset_outputs(string tag);
        check(tag, {bus.o_Req0_Ack, bus.o_Req1_Ack, bus.o_Tx_DV, bus.o_Busy, bus.o_Grant,
                    bus.o_Word_Done, bus.o_Byte_Idx, bus.o_Tx_Byte}, 0);
    endtask

    initial begin
        logic [8*NB-1:0] w, wa, wb, w0a, w0b, w1a, w1b;
        int t0;
        bus.i_Tx_Active = 1'b0;
        bus.i_Tx_Done   = 1'b0;
        drive_reqs();
        step();
        step();
        check_reset_outputs("reset_outputs");
        i_Reset = 1'b0;
        step();

        // Single word from req0, byte k = k
        for (int k = 0; k < NB; k++) w[8*k +: 8] = 8'(k);
        q0.push_back(w);
        drive_reqs();
        t0 = cyc;
        wait_words(1, "single_timeout");
        check("ack_latency", ack_cyc - t0, 1);
        check("first_dv_latency", dv0_cyc - t0, 2);
        check("single_dv_count", seen.size(), NB);
        check("single_done_count", wd_cnt, 1);
        check_acks("single_acks", 0, 0, 1);
        check_word("single_bytes", w, 1'b0, 0);

        // Tie after reset: req0 first, then req1
        do_reset();
        wa = {NB{8'hAA}};
        wb = {NB{8'h55}};
        q0.push_back(wa);
        q1.push_back(wb);
        drive_reqs();
        wait_words(2, "tie_timeout");
        check_acks("tie_acks", 0, 1, 2);
        check_word("tie_word0", wa, 1'b0, 0);
        check_word("tie_word1", wb, 1'b1, NB);

        // Reset while byte 10 is in flight
        do_reset();
        w = rand_word();
        q0.push_back(w);
        drive_reqs();
        wait_dv(11, "byte10_timeout");
        i_Reset = 1'b1;
        step();
        check_reset_outputs("reset_mid_word");
        i_Reset = 1'b0;
        seen.delete();
        ack_ids.delete();
        wd_cnt = 0;
        w = rand_word();
        q1.push_back(w);
        drive_reqs();
        wait_words(1, "post_reset_timeout");
        check_acks("post_reset_acks", 1, 1, 1);
        check_word("post_reset_bytes", w, 1'b1, 0);

        // Req1 valid pulse while busy is ignored
        do_reset();
        w = rand_word();
        junk1 = rand_word();
        q0.push_back(w);
        drive_reqs();
        wait_dv(5, "byte4_timeout");
        pulse1 = 1'b1;
        for (int i = 0; i < 3; i++) step();
        pulse1 = 1'b0;
        drive_reqs();
        wait_words(1, "ignore_timeout");
        for (int i = 0; i < 10; i++) step();
        check_acks("ignore_acks", 0, 0, 1);
        check_word("ignore_bytes", w, 1'b0, 0);

        // Continuous contention, two words each
        do_reset();
        w0a = rand_word();
        w0b = rand_word();
        w1a = rand_word();
        w1b = rand_word();
        q0.push_back(w0a);
        q0.push_back(w0b);
        q1.push_back(w1a);
        q1.push_back(w1b);
        drive_reqs();
        wait_words(4, "contend_timeout");
        check("contend_done_count", wd_cnt, 4);
        check("contend_ack_count", ack_ids.size(), 4);
        check("contend_grants_n", gnt_seen.size(), 4);
        for (int i = 0; i < 4 && i < gnt_seen.size(); i++) check("contend_grant", gnt_seen[i], i % 2);
        for (int i = 0; i < 4 && i < ack_ids.size(); i++) check("contend_ack", ack_ids[i], i % 2);
        check_word("contend_w0a", w0a, 1'b0, 0);
        check_word("contend_w1a", w1a, 1'b1, NB);
        check_word("contend_w0b", w0b, 1'b0, 2 * NB);
        check_word("contend_w1b", w1b, 1'b1, 3 * NB);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/uart_word_tx_ctrl.md
# uart_word_tx_ctrl

Controller that shares the byte-wide UART transmitter (`uart_tx`) between two 256-bit result producers in the SIMD FIR datapath.
- Each requester presents a full word.
- The controller grants one word at a time, round-robin.
- It serializes the granted word into `NUM_BYTES` single-byte transmissions, LSB byte first.
- It sequences each byte through the transmitter's DV/Active/Done handshake.

## Interface
- `NUM_BYTES`, 32: bytes per word. The word width is 8*`NUM_BYTES`.
- `i_Clock`  in  1  system clock. This is the single clock; all logic is on its rising edge.
- `i_Reset`  in  1  synchronous, active-high reset.
- `i_Req0_Valid`  in  1  requester 0 has a word. It is held with the word until ack.
- `i_Req0_Word`  in  8*NUM_BYTES  requester 0 word.
- `o_Req0_Ack`  out  1  one-cycle pulse: requester 0's word has been captured.
- `i_Req1_Valid`, `i_Req1_Word`, `o_Req1_Ack`: same as requester 0, for requester 1.
- `o_Tx_DV`  out  1  one-cycle start pulse to the transmitter.
- `o_Tx_Byte`  out  8  byte to the transmitter. It drives the low 8 bits of the transmitter data input; the upper bits are tied 0.
- `i_Tx_Active`  in  1  transmitter active flag.
- `i_Tx_Done`  in  1  transmitter done flag.
- `o_Busy`  out  1  high in every state except IDLE.
- `o_Grant`  out  1  ID of the requester whose word is in flight.
- `o_Byte_Idx`  out  $clog2(NUM_BYTES)  index of the byte currently in flight.
- `o_Word_Done`  out  1  one-cycle pulse after the last byte's Done.

## Operation
- **States:** IDLE, SEND, WAIT_ACT, WAIT_DONE, WAIT_REL.
- **IDLE:**
  - Eligible only when `i_Tx_Active`=0 and `i_Tx_Done`=0.
  - If either valid is high, pick a winner:
    - If only one requester is valid, it wins.
    - If both are valid, the requester that is not `r_Last` wins.
  - Latch the winner's word, set `o_Grant`, clear `o_Byte_Idx`, go to SEND.
- **SEND:** drive `o_Tx_Byte` = word[8*idx+7 : 8*idx], pulse `o_Tx_DV`, go to WAIT_ACT.
- **WAIT_ACT:** stay until `i_Tx_Active`=1, then go to WAIT_DONE.
- **WAIT_DONE:** stay until `i_Tx_Done`=1.
  - If idx = NUM_BYTES-1: pulse `o_Word_Done`, set `r_Last` = `o_Grant`.
  - Otherwise: idx+1.
  - In both cases go to WAIT_REL.
- **WAIT_REL:** stay until `i_Tx_Done`=0.
  - Go to SEND if bytes remain, else to IDLE.
  - `i_Tx_Done` stays high for 2 cycles after a byte. Issuing DV before it falls is forbidden.
- **Byte index:**
  - `o_Byte_Idx` wraps NUM_BYTES-1 → 0 only via IDLE, never by arithmetic overflow.
  - NUM_BYTES must be a power of two ≥ 2.
- **Valid rules:**
  - A requester deasserting valid before ack is legal; it simply loses that arbitration.
  - Valid is ignored in every state except IDLE.

## Timing
- **Reset values:**
  - Every output is 0.
  - State is IDLE.
  - `r_Last` = 1, so requester 0 wins the first tie.
- **Reset mid-word:**
  - State returns to IDLE and the word is discarded; no ack is re-issued.
  - The transmitter is not reset. The IDLE eligibility check delays the next grant until its in-flight byte finishes.
- **Grant timing:**
  - Valid is sampled in IDLE at edge T.
  - `o_ReqN_Ack`=1 and `o_Busy`=1 during cycle T+1 (registered).
  - `o_Tx_DV`=1 during cycle T+2, exactly one cycle, with `o_Tx_Byte` stable from T+2 until the next SEND.
- **Word done and back-to-back:**
  - `o_Word_Done` is high in the cycle after Done is sampled.
  - The earliest next grant is the cycle after WAIT_REL observes Done=0.
- **Simultaneous valid:** a pending opposite requester is never starved; grants strictly alternate under continuous contention.

## Structure
- **Package `uart_ctrl_pkg`:**
  - state enum (3-bit: IDLE=0, SEND=1, WAIT_ACT=2, WAIT_DONE=3, WAIT_REL=4);
  - requester ID constants REQ0=0, REQ1=1.
- **Sub-module `rr_arb2`:**
  - combinational 2-way round-robin pick;
  - inputs: two valids, `last`;
  - outputs: `gnt_valid`, `gnt_id`.
- **Main FSM plus word/index registers:** in `uart_word_tx_ctrl`.

## Test plan
Use a behavioural transmitter model with CLKS_PER_BIT=4.
- **Single word, req0 only:** word = 0x1F..0100 (byte k = k) → bytes 0x00..0x1F on `o_Tx_Byte`, in order, 32 DV pulses, one ack, one `o_Word_Done`.
- **Tie:** both valid at the same cycle after reset, req0 = all 0xAA, req1 = all 0x55 → req0 served first, then req1, alternating; acks are 1 cycle each.
- **Done handshake:** the model holds Done for 2 cycles → no DV while Done=1; the DV-to-DV spacing matches the model's frame length plus WAIT_REL exit.
- **Reset at byte 10 of a word:**
  - all outputs are 0 the next cycle;
  - no DV until the model's Active and Done are both 0;
  - a new word then starts at byte 0.
- **Valid ignored while busy:** req1 pulses valid mid-word for 3 cycles, then drops → no ack to req1; req0's word completes intact.
- **Continuous contention, 4 words:** grant sequence is 0, 1, 0, 1; `o_Word_Done` count = 4.
